// File: rtl/mio_pkg.sv
// Shared address map, IO offsets, state encoding and region type for the MIO responder.
package mio_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_LIMIT = 32'h0000_0FFF;
  localparam logic [31:0] ROM_BASE  = 32'h3000_0000;
  localparam logic [31:0] ROM_LIMIT = 32'h3000_0FFF;
  localparam logic [31:0] IO_BASE   = 32'hF000_0000;

  localparam logic [31:0] LED_OFS   = 32'h0000_0000;
  localparam logic [31:0] SW_OFS    = 32'h0000_0004;
  localparam logic [31:0] CNT_OFS   = 32'h0000_0008;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    MEMWAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic ram;
    logic rom;
    logic led;
    logic sw;
    logic cnt;
    logic unmapped;
  } region_t;

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address decoder: one-hot region select plus word-alignment flag.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [31:0] M_addr,
  output region_t     region,
  output logic        misaligned
);

  logic [31:0] word_addr;

  // IO registers are matched on the word address so a misaligned IO access still lands in a region
  assign word_addr = {M_addr[31:2], 2'b00};

  always_comb begin
    region     = '0;
    misaligned = (M_addr[1:0] != 2'b00);
    if (in_range(M_addr, RAM_BASE, RAM_LIMIT))
      region.ram = 1'b1;
    else if (in_range(M_addr, ROM_BASE, ROM_LIMIT))
      region.rom = 1'b1;
    else if (word_addr == IO_BASE + LED_OFS)
      region.led = 1'b1;
    else if (word_addr == IO_BASE + SW_OFS)
      region.sw = 1'b1;
    else if (word_addr == IO_BASE + CNT_OFS)
      region.cnt = 1'b1;
    else
      region.unmapped = 1'b1;
  end

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder: registers a CPU request, services RAM/ROM/IO and strobes MIO_ready.
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int ROM_AW = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_req,
  input  logic              mem_w,
  input  logic [31:0]       M_addr,
  input  logic [31:0]       data_out,
  output logic [31:0]       data2CPU,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [7:0]        led_out,
  input  logic [7:0]        sw_in,
  output logic              bus_err
);

  state_t      state;
  region_t     dec_region;
  region_t     region;
  logic        dec_misaligned;
  logic        misaligned;
  logic        is_write;
  logic [31:0] wdata;
  logic [31:0] cnt;

  mio_addr_decode u_decode (
    .M_addr     (M_addr),
    .region     (dec_region),
    .misaligned (dec_misaligned)
  );

  // Gated by reset_n so a reset landing in ACCESS cannot commit the RAM write on that same edge
  assign ram_we    = reset_n && (state == ACCESS) && is_write && region.ram && !misaligned;
  assign MIO_ready = (state == DONE);
  assign ram_wdata = wdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      data2CPU   <= '0;
      led_out    <= '0;
      cnt        <= '0;
      bus_err    <= 1'b0;
      ram_addr   <= '0;
      rom_addr   <= '0;
      region     <= '0;
      misaligned <= 1'b0;
      is_write   <= 1'b0;
      wdata      <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      case (state)
        IDLE: begin
          if (mem_req) begin
            region     <= dec_region;
            misaligned <= dec_misaligned;
            is_write   <= mem_w;
            wdata      <= data_out;
            ram_addr   <= M_addr[RAM_AW+1:2];
            rom_addr   <= M_addr[ROM_AW+1:2];
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          state <= DONE;
          if (misaligned) begin
            bus_err <= 1'b1;
            if (!is_write)
              data2CPU <= '0;
          end else if (is_write) begin
            if (region.led)
              led_out <= wdata[7:0];
            else if (region.cnt)
              cnt <= '0;
            else if (region.rom || region.sw || region.unmapped)
              bus_err <= 1'b1;
          end else begin
            if (region.ram || region.rom)
              state <= MEMWAIT;
            else if (region.led)
              data2CPU <= {24'b0, led_out};
            else if (region.sw)
              data2CPU <= {24'b0, sw_in};
            else if (region.cnt)
              data2CPU <= cnt;
            else if (region.unmapped) begin
              data2CPU <= DEAD_BEEF;
              bus_err  <= 1'b1;
            end
          end
        end
        MEMWAIT: begin
          data2CPU <= region.ram ? ram_rdata : rom_data;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Directed bench for mio_responder with behavioural sync RAM/ROM models.
module tb_mio_responder;
  import mio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] M_addr = '0;
  logic [31:0] data_out = '0;
  logic [31:0] data2CPU;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [7:0]  led_out;
  logic [7:0]  sw_in = '0;
  logic        bus_err;

  logic [31:0] ram [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          ready_cnt = 0;
  logic [9:0]  we_addr = '0;

  mio_responder #(.RAM_AW(10), .ROM_AW(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_w     (mem_w),
    .M_addr    (M_addr),
    .data_out  (data_out),
    .data2CPU  (data2CPU),
    .MIO_ready (MIO_ready),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .led_out   (led_out),
    .sw_in     (sw_in),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
    rom_data  <= (rom_addr == 10'd0) ? 32'h2008_0001 : {22'b0, rom_addr};
  end

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
    end
    if (MIO_ready) ready_cnt <= ready_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    mem_req  = 1'b1;
    mem_w    = w;
    M_addr   = a;
    data_out = d;
    lat      = 0;
    rd       = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (MIO_ready) begin
        lat = i;
        rd  = data2CPU;
        break;
      end
    end
    mem_req = 1'b0;
    mem_w   = 1'b0;
    tick();
    check("ready_one_cycle", {31'b0, MIO_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          we0;
    int          rdy0;

    for (int i = 0; i < 1024; i++) ram[i] = '0;

    repeat (3) tick();
    check("rst_data2CPU", data2CPU, 32'd0);
    check("rst_ready", {31'b0, MIO_ready}, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check("rst_led", {24'b0, led_out}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_ram_addr", {22'b0, ram_addr}, 32'd0);
    check("rst_rom_addr", {22'b0, rom_addr}, 32'd0);
    check("rst_cnt", dut.cnt, 32'd0);
    check("rst_state", {30'b0, dut.state}, {30'b0, IDLE});
    reset_n = 1'b1;
    tick();

    // RAM write then read back
    we0 = we_cnt;
    access(1'b1, 32'h0000_0010, 32'h1234_5678, rd, lat);
    check("ram_wr_lat", lat, 32'd2);
    check("ram_we_pulses", we_cnt - we0, 32'd1);
    check("ram_we_addr", {22'b0, we_addr}, 32'd4);
    access(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    check("ram_rd_data", rd, 32'h1234_5678);
    check("ram_rd_lat", lat, 32'd3);

    // ROM reads
    access(1'b0, 32'h3000_0000, 32'h0, rd, lat);
    check("rom_rd_data", rd, 32'h2008_0001);
    check("rom_rd_lat", lat, 32'd3);
    check("rom_bus_err", {31'b0, bus_err}, 32'd0);
    access(1'b0, 32'h3000_0008, 32'h0, rd, lat);
    check("rom_rd_word2", rd, 32'h0000_0002);

    // LED / SW
    access(1'b1, 32'hF000_0000, 32'hFFFF_FFA5, rd, lat);
    check("led_wr_lat", lat, 32'd2);
    check("led_out", {24'b0, led_out}, 32'h0000_00A5);
    check("hold_after_write", data2CPU, 32'h0000_0002);
    sw_in = 8'h3C;
    access(1'b0, 32'hF000_0004, 32'h0, rd, lat);
    check("sw_rd_data", rd, 32'h0000_003C);
    check("sw_rd_lat", lat, 32'd2);
    access(1'b0, 32'hF000_0000, 32'h0, rd, lat);
    check("led_rd_data", rd, 32'h0000_00A5);
    check("io_bus_err", {31'b0, bus_err}, 32'd0);

    // CNT wrap from all-ones
    force dut.cnt = 32'hFFFF_FFFF;
    tick();
    release dut.cnt;
    tick();
    check("cnt_wrap", dut.cnt, 32'd0);
    tick();
    check("cnt_after_wrap", dut.cnt, 32'd1);

    // CNT write colliding with the increment: write must win
    mem_req  = 1'b1;
    mem_w    = 1'b1;
    M_addr   = 32'hF000_0008;
    data_out = 32'h0;
    tick();
    mem_req = 1'b0;
    mem_w   = 1'b0;
    force dut.cnt = 32'd100;
    #1;
    release dut.cnt;
    tick();
    check("cnt_clear_wins", dut.cnt, 32'd0);
    check("cnt_wr_ready", {31'b0, MIO_ready}, 32'd1);
    tick();
    check("cnt_after_clear", dut.cnt, 32'd1);

    // Error cases
    access(1'b0, 32'h4000_0000, 32'h0, rd, lat);
    check("unmapped_rd_data", rd, 32'hDEAD_BEEF);
    check("unmapped_rd_lat", lat, 32'd2);
    check("unmapped_bus_err", {31'b0, bus_err}, 32'd1);
    we0 = we_cnt;
    access(1'b1, 32'h0000_0012, 32'hFFFF_FFFF, rd, lat);
    check("misalign_wr_lat", lat, 32'd2);
    check("misalign_no_we", we_cnt - we0, 32'd0);
    access(1'b0, 32'h0000_0011, 32'h0, rd, lat);
    check("misalign_rd_zero", rd, 32'd0);
    access(1'b1, 32'h3000_0000, 32'h5555_5555, rd, lat);
    check("rom_wr_lat", lat, 32'd2);
    access(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    check("ram_intact", rd, 32'h1234_5678);
    check("bus_err_sticky", {31'b0, bus_err}, 32'd1);

    // Reset during ACCESS of a RAM write
    we0  = we_cnt;
    rdy0 = ready_cnt;
    mem_req  = 1'b1;
    mem_w    = 1'b1;
    M_addr   = 32'h0000_0020;
    data_out = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    mem_req = 1'b0;
    mem_w   = 1'b0;
    tick();
    tick();
    check("abort_state", {30'b0, dut.state}, {30'b0, IDLE});
    check("abort_bus_err", {31'b0, bus_err}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("abort_no_we", we_cnt - we0, 32'd0);
    check("abort_no_ready", ready_cnt - rdy0, 32'd0);
    access(1'b0, 32'h0000_0020, 32'h0, rd, lat);
    check("abort_ram_unchanged", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mio_responder.md
MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning RAM word-address width (4 KB).
REQ-002 SHALL have parameter ROM_AW, default 10, meaning ROM word-address width (4 KB).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port mem_req, input, 1, CPU access request, held by the CPU until MIO_ready.
REQ-006 SHALL have port mem_w, input, 1, 1 = write, 0 = read, qualified by mem_req.
REQ-007 SHALL have port M_addr, input, 32, CPU byte address.
REQ-008 SHALL have port data_out, input, 32, CPU write data.
REQ-009 SHALL have port data2CPU, output, 32, read data to the CPU.
REQ-010 SHALL have port MIO_ready, output, 1, one-cycle access-complete strobe.
REQ-011 SHALL have ram_addr (output, RAM_AW), ram_we (output, 1), ram_wdata (output, 32) and ram_rdata (input, 32), a synchronous RAM port with 1-cycle read latency.
REQ-012 SHALL have rom_addr (output, ROM_AW) and rom_data (input, 32), a synchronous ROM port with 1-cycle latency.
REQ-013 SHALL have led_out (output, 8), sw_in (input, 8) and bus_err (output, 1, sticky error flag).

Function
REQ-014 SHALL decode the address map:
- RAM: 0x0000_0000-0x0000_0FFF
- ROM: 0x3000_0000-0x3000_0FFF
- LED: 0xF000_0000, R/W
- SW: 0xF000_0004, R
- CNT: 0xF000_0008, R; a write clears it
- any other address is unmapped.
REQ-015 SHALL implement FSM states IDLE, ACCESS, MEMWAIT, DONE.
REQ-016 SHALL, in IDLE, sample mem_req=1 in cycle T, register address, data and direction, and go to ACCESS.
REQ-017 SHALL, in ACCESS (T+1), do the following:
- RAM/ROM read: drive the address and go to MEMWAIT.
- RAM write: pulse ram_we for exactly one cycle and go to DONE.
- IO or unmapped access: complete and go to DONE.
REQ-018 SHALL, in MEMWAIT (T+2), register ram_rdata/rom_data into data2CPU and go to DONE.
REQ-019 SHALL, in DONE, assert MIO_ready for exactly one cycle and return to IDLE. Read latency from request to ready: 3 cycles for RAM/ROM, 2 cycles for IO/writes.
REQ-020 SHALL hold data2CPU stable from the MIO_ready cycle until the next read completes.
REQ-021 SHALL ignore mem_req outside IDLE; a held request is re-sampled only in IDLE, earliest the cycle after MIO_ready.
REQ-022 SHALL use word addressing only. If M_addr[1:0] != 0, it performs no write, returns 0 on reads, sets bus_err, and still completes with MIO_ready.
REQ-023 SHALL, for a write to ROM or SW: perform no state change, set bus_err, and complete normally.
REQ-024 SHALL, for an unmapped read: return 0xDEAD_BEEF, set bus_err, and complete normally. An unmapped write is dropped and sets bus_err.
REQ-025 SHALL make CNT a free-running 32-bit counter, +1 per clock, wrapping 0xFFFF_FFFF -> 0. A CNT write in the same cycle as an increment wins: CNT = 0 on the next cycle.
REQ-026 SHALL write led_out from data_out[7:0]; a LED read returns {24'b0, led_out}.
REQ-027 SHALL make SW reads return {24'b0, sw_in} as sampled in the ACCESS cycle.
REQ-028 SHALL keep bus_err set until reset.

Reset
REQ-029 SHALL, when reset_n=0 at a clock edge, set:
- state = IDLE
- MIO_ready = 0, ram_we = 0
- data2CPU = 0, led_out = 0, CNT = 0, bus_err = 0
- ram_addr = 0, rom_addr = 0
REQ-030 SHALL abort any in-flight access on reset (including in ACCESS) with no RAM write committed and no MIO_ready issued.

Structure
REQ-031 SHALL place in shared package mio_pkg:
- address-map base/limit constants
- IO register offsets
- the 0xDEAD_BEEF constant
- the FSM state enum
REQ-032 SHALL put address decode in one combinational sub-module, mio_addr_decode. It takes M_addr and outputs a one-hot region {RAM, ROM, LED, SW, CNT, UNMAPPED} plus a misaligned flag.

Verification
REQ-033 SHALL cover: RAM write 0x1234_5678 to 0x0000_0010, then read the same address -> ram_we pulses once with ram_addr=4; the read returns 0x1234_5678 with MIO_ready 3 cycles after the request.
REQ-034 SHALL cover: ROM read at 0x3000_0000 with rom_data=0x2008_0001 -> data2CPU=0x2008_0001, MIO_ready one cycle, bus_err=0.
REQ-035 SHALL cover: LED write 0xA5 then SW read with sw_in=0x3C -> led_out=0xA5, data2CPU=0x0000_003C, each access 2 cycles to ready.
REQ-036 SHALL cover: a read of 0x4000_0000, then a write of 0x0000_0012 -> data2CPU=0xDEAD_BEEF; ram_we stays 0; bus_err=1 and sticky.
REQ-037 SHALL cover: CNT preloaded to 0xFFFF_FFFF via force, then CNT written -> the counter wraps to 0; the write-vs-increment collision yields 0.
REQ-038 SHALL cover: reset_n=0 asserted during ACCESS of a RAM write -> ram_we never pulses, MIO_ready stays 0, FSM is in IDLE after reset.
